// File: rtl/karatsuba_pp_gen_24bit.sv
// rtl/karatsuba_pp_gen_24bit.sv - one-level Karatsuba partial-product generator for GF(2) polynomials.
// One bit-serial h x h carry-less multiplier is time-shared across the low, high and middle products.
module karatsuba_pp_gen_24bit #(
  parameter int n = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a_in,
  input  logic [n-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-2:0] pp_lo_out,
  output logic [n-2:0] pp_mid_out,
  output logic [n-2:0] pp_hi_out
);

  localparam int h  = n / 2;
  localparam int CW = (h > 1) ? $clog2(h) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [n-1:0]   r_a;
  logic [n-1:0]   r_b;
  logic [n-2:0]   r_acc;
  logic [CW-1:0]  r_count;
  logic [n-2:0]   r_pp_lo;
  logic [n-2:0]   r_pp_mid;
  logic [n-2:0]   r_pp_hi;

  logic [h-1:0]   w_a_sel;
  logic [h-1:0]   w_b_sel;
  logic [CW-1:0]  w_bit_idx;
  logic           w_last;
  logic [n-2:0]   w_acc_next;

  // Multiplier bits are consumed MSB first so the accumulator only ever shifts left.
  assign w_bit_idx  = CW'(h - 1) - r_count;
  assign w_last     = (r_count == CW'(h - 1));
  assign w_acc_next = (r_acc << 1)
                    ^ (w_b_sel[w_bit_idx] ? {{(n-1-h){1'b0}}, w_a_sel} : '0);

  always_comb begin
    w_a_sel = r_a[h-1:0];
    w_b_sel = r_b[h-1:0];
    case (r_state)
      MUL_HI: begin
        w_a_sel = r_a[n-1:h];
        w_b_sel = r_b[n-1:h];
      end
      MUL_MID: begin
        w_a_sel = r_a[h-1:0] ^ r_a[n-1:h];
        w_b_sel = r_b[h-1:0] ^ r_b[n-1:h];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = MUL_LO;
      MUL_LO:  if (w_last)    w_state_next = MUL_HI;
      MUL_HI:  if (w_last)    w_state_next = MUL_MID;
      MUL_MID: if (w_last)    w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_pp_lo  <= '0;
      r_pp_mid <= '0;
      r_pp_hi  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        MUL_LO, MUL_HI, MUL_MID: begin
          if (w_last) begin
            r_count <= '0;
            r_acc   <= '0;
            if (r_state == MUL_LO) r_pp_lo <= w_acc_next;
            if (r_state == MUL_HI) r_pp_hi <= w_acc_next;
            // Middle term is corrected here so the overlap stage only has to XOR.
            if (r_state == MUL_MID) r_pp_mid <= w_acc_next ^ r_pp_lo ^ r_pp_hi;
          end else begin
            r_count <= r_count + CW'(1);
            r_acc   <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == HOLD);
  assign pp_lo_out  = r_pp_lo;
  assign pp_mid_out = r_pp_mid;
  assign pp_hi_out  = r_pp_hi;

endmodule

// File: tb/tb_karatsuba_pp_gen_24bit.sv
// tb/tb_karatsuba_pp_gen_24bit.sv - randomized self-checking bench for karatsuba_pp_gen_24bit.
// Reference: plain shift-and-XOR carry-less multiplication of the full and split operands.
module tb_karatsuba_pp_gen_24bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a_in;
  logic [23:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] pp_lo_out;
  logic [22:0] pp_mid_out;
  logic [22:0] pp_hi_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  karatsuba_pp_gen_24bit #(.n(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pp_lo_out  (pp_lo_out),
    .pp_mid_out (pp_mid_out),
    .pp_hi_out  (pp_hi_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r = '0;
    for (int i = 0; i < 32; i++)
      if (y[i]) r ^= ({32'b0, x} << i);
    return r;
  endfunction

  // Runs one operation up to HOLD and checks its products; the bench is left at a negedge in HOLD.
  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input string tag,
                       input bit chk_lat, input bit rnd_ready,
                       output logic [22:0] e_lo, output logic [22:0] e_mid, output logic [22:0] e_hi,
                       output bit ok);
    int cyc;
    logic [63:0] overlap;
    e_lo  = 23'(clmul({20'b0, a[11:0]}, {20'b0, b[11:0]}));
    e_hi  = 23'(clmul({20'b0, a[23:12]}, {20'b0, b[23:12]}));
    e_mid = 23'(clmul({20'b0, a[11:0] ^ a[23:12]}, {20'b0, b[11:0] ^ b[23:12]})) ^ e_lo ^ e_hi;
    ok = 1'b0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    a_in      = 24'($urandom);
    b_in      = 24'($urandom);
    out_ready = rnd_ready ? 1'($urandom) : 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) begin
        check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    if (chk_lat) check({tag, "_latency"}, 64'(cyc), 64'd36);
    check({tag, "_lo"},  64'(pp_lo_out),  64'(e_lo));
    check({tag, "_mid"}, 64'(pp_mid_out), 64'(e_mid));
    check({tag, "_hi"},  64'(pp_hi_out),  64'(e_hi));
    overlap = 64'(pp_lo_out) ^ (64'(pp_mid_out) << 12) ^ (64'(pp_hi_out) << 24);
    check({tag, "_overlap"}, overlap, clmul({8'b0, a}, {8'b0, b}));
    check({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
    ok = 1'b1;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  logic [23:0] dir_a [6] = '{24'h000001, 24'h000003, 24'hFFFFFF, 24'h001000, 24'hFFFFFF, 24'h123456};
  logic [23:0] dir_b [6] = '{24'h000001, 24'h000003, 24'h000001, 24'h001000, 24'hFFFFFF, 24'hABCDEF};

  initial begin
    logic [22:0] e_lo, e_mid, e_hi;
    bit ok;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),   64'd1);
    check("rst_out_valid", 64'(out_valid),  64'd0);
    check("rst_lo",        64'(pp_lo_out),  64'd0);
    check("rst_mid",       64'(pp_mid_out), 64'd0);
    check("rst_hi",        64'(pp_hi_out),  64'd0);
    rst = 1'b0;

    // Directed vectors, with hand-derived values checked alongside the model.
    for (int i = 0; i < 6; i++) begin
      do_op(dir_a[i], dir_b[i], $sformatf("dir%0d", i), 1'b1, 1'b0, e_lo, e_mid, e_hi, ok);
      if (ok) begin
        case (i)
          0: check("basic_lo_const", 64'(pp_lo_out), 64'h1);
          1: check("square_lo_const", 64'(pp_lo_out), 64'h5);
          2: check("mid_const", 64'(pp_mid_out), 64'hFFF);
          3: check("hi_const", 64'(pp_hi_out), 64'h1);
          4: check("ones_hi_const", 64'(pp_hi_out), 64'h555555);
          default: ;
        endcase
        handshake($sformatf("dir%0d", i));
      end
    end

    // Backpressure: outputs hold steady for 10 cycles without out_ready.
    do_op(24'($urandom), 24'($urandom), "bp", 1'b1, 1'b0, e_lo, e_mid, e_hi, ok);
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        @(negedge clk);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_ready", 64'(in_ready), 64'd0);
        check("bp_lo",  64'(pp_lo_out),  64'(e_lo));
        check("bp_mid", 64'(pp_mid_out), 64'(e_mid));
        check("bp_hi",  64'(pp_hi_out),  64'(e_hi));
      end
      handshake("bp");
    end

    // Reset about 20 cycles into an operation.
    @(negedge clk);
    in_valid = 1'b1;
    a_in = 24'h7A5C3E;
    b_in = 24'h1F0E2D;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_lo",  64'(pp_lo_out),  64'd0);
    check("midrst_mid", 64'(pp_mid_out), 64'd0);
    check("midrst_hi",  64'(pp_hi_out),  64'd0);
    do_op(24'h000003, 24'h000003, "post_rst", 1'b1, 1'b0, e_lo, e_mid, e_hi, ok);
    if (ok) begin
      check("post_rst_lo_const", 64'(pp_lo_out), 64'h5);
      handshake("post_rst");
    end

    // Random pairs, with out_ready toggled during computation where it must be ignored.
    for (int i = 0; i < 1000; i++) begin
      do_op(24'($urandom), 24'($urandom), "rnd", 1'b0, 1'b1, e_lo, e_mid, e_hi, ok);
      if (!ok) break;
      handshake("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
